// File: rtl/softmax_seq_ctrl_if.sv
// Host <-> sequencer bundle for the 4-lane softmax datapath controller.
// master = host issuing start/bounds; slave = sequencer driving addresses, enables and status.
// Backpressure: none; start is a level sampled only when the sequencer is idle.
interface softmax_seq_ctrl_if #(
    parameter int ADDRSIZE = 8,
    parameter int CNTW     = 16
);
    logic                start;
    logic [ADDRSIZE-1:0] start_addr;
    logic [ADDRSIZE-1:0] end_addr;
    logic [ADDRSIZE-1:0] addr;
    logic [ADDRSIZE-1:0] sub0_addr;
    logic [ADDRSIZE-1:0] sub1_addr;
    logic                max_en;
    logic                sub_en;
    logic                exp_en;
    logic                add_en;
    logic                log_en;
    logic                presub_en;
    logic                logsub_en;
    logic                exp2_en;
    logic                out_valid;
    logic                busy;
    logic                done;
    logic [CNTW-1:0]     cycle_cnt;

    modport master (
        output start, start_addr, end_addr,
        input  addr, sub0_addr, sub1_addr, max_en, sub_en, exp_en, add_en, log_en,
               presub_en, logsub_en, exp2_en, out_valid, busy, done, cycle_cnt
    );

    modport slave (
        input  start, start_addr, end_addr,
        output addr, sub0_addr, sub1_addr, max_en, sub_en, exp_en, add_en, log_en,
               presub_en, logsub_en, exp2_en, out_valid, busy, done, cycle_cnt
    );
endinterface

// File: rtl/softmax_seq_ctrl.sv
// Single-clock pass sequencer for the softmax datapath; optional SOFTMAX_CYCLE_CNT_EN adds a busy-cycle counter.
// Latency: 3N+10 cycles from accepted start to done (1 cycle for an empty range).
// Backpressure: none; start is ignored while busy, including the done cycle.
module softmax_seq_ctrl #(
    parameter int ADDRSIZE = 8,
    parameter int CNTW     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    softmax_seq_ctrl_if.slave     bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_MAX, S_MAX_DRAIN, S_SUMEXP, S_SUM_DRAIN,
        S_LOG, S_NORM, S_NORM_DRAIN, S_DONE
    } state_t;

    state_t              state;
    logic [ADDRSIZE-1:0] start_q, last_q, rem;
    logic [ADDRSIZE-1:0] addr, sub0_addr, sub1_addr;
    logic max_en, sub_en, exp_en, add_en, log_en;
    logic presub_en, logsub_en, exp2_en, out_valid, busy, done;

    // Stage enables are delay lines off the per-pass issue states, so each
    // stage sees exactly N contiguous pulses one cycle after its input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            start_q   <= '0;
            last_q    <= '0;
            rem       <= '0;
            addr      <= '0;
            sub0_addr <= '0;
            sub1_addr <= '0;
            max_en    <= 1'b0;
            sub_en    <= 1'b0;
            exp_en    <= 1'b0;
            add_en    <= 1'b0;
            log_en    <= 1'b0;
            presub_en <= 1'b0;
            logsub_en <= 1'b0;
            exp2_en   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            max_en    <= (state == S_MAX);
            sub_en    <= (state == S_SUMEXP);
            exp_en    <= sub_en;
            add_en    <= exp_en;
            presub_en <= (state == S_NORM);
            logsub_en <= presub_en;
            exp2_en   <= logsub_en;
            out_valid <= exp2_en;
            log_en    <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        busy <= 1'b1;
                        if (bus.end_addr > bus.start_addr) begin
                            start_q <= bus.start_addr;
                            last_q  <= bus.end_addr - bus.start_addr - 1'b1;
                            rem     <= bus.end_addr - bus.start_addr - 1'b1;
                            addr    <= bus.start_addr;
                            state   <= S_MAX;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_MAX: begin
                    if (rem == '0) begin
                        state <= S_MAX_DRAIN;
                    end else begin
                        addr <= addr + 1'b1;
                        rem  <= rem - 1'b1;
                    end
                end
                S_MAX_DRAIN: begin
                    sub0_addr <= start_q;
                    rem       <= last_q;
                    state     <= S_SUMEXP;
                end
                S_SUMEXP: begin
                    if (rem == '0) begin
                        rem   <= ADDRSIZE'(2);
                        state <= S_SUM_DRAIN;
                    end else begin
                        sub0_addr <= sub0_addr + 1'b1;
                        rem       <= rem - 1'b1;
                    end
                end
                S_SUM_DRAIN: begin
                    if (rem == '0) begin
                        log_en <= 1'b1;
                        state  <= S_LOG;
                    end else begin
                        rem <= rem - 1'b1;
                    end
                end
                S_LOG: begin
                    sub1_addr <= start_q;
                    rem       <= last_q;
                    state     <= S_NORM;
                end
                S_NORM: begin
                    if (rem == '0) begin
                        rem   <= ADDRSIZE'(3);
                        state <= S_NORM_DRAIN;
                    end else begin
                        sub1_addr <= sub1_addr + 1'b1;
                        rem       <= rem - 1'b1;
                    end
                end
                S_NORM_DRAIN: begin
                    if (rem == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        rem <= rem - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SOFTMAX_CYCLE_CNT_EN
    logic [CNTW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (state == S_IDLE && bus.start)
            cnt <= '0;
        else if (busy && cnt != {CNTW{1'b1}})
            cnt <= cnt + 1'b1;
    end

    assign bus.cycle_cnt = cnt;
`else
    assign bus.cycle_cnt = {CNTW{1'b0}};
`endif

    assign bus.addr      = addr;
    assign bus.sub0_addr = sub0_addr;
    assign bus.sub1_addr = sub1_addr;
    assign bus.max_en    = max_en;
    assign bus.sub_en    = sub_en;
    assign bus.exp_en    = exp_en;
    assign bus.add_en    = add_en;
    assign bus.log_en    = log_en;
    assign bus.presub_en = presub_en;
    assign bus.logsub_en = logsub_en;
    assign bus.exp2_en   = exp2_en;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.done      = done;
endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Directed bench for softmax_seq_ctrl: per-cycle enables, addresses and counter against hand-derived schedules.
module tb_softmax_seq_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    softmax_seq_ctrl_if #(.ADDRSIZE(8), .CNTW(16)) bus ();

    softmax_seq_ctrl #(.ADDRSIZE(8), .CNTW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [10:0] cap_ctl [0:1023];
    logic [7:0]  cap_a   [0:1023];
    logic [7:0]  cap_s0  [0:1023];
    logic [7:0]  cap_s1  [0:1023];
    logic [15:0] cap_cnt [0:1023];

    function automatic logic [10:0] ctl_now();
        return {bus.max_en, bus.sub_en, bus.exp_en, bus.add_en, bus.log_en,
                bus.presub_en, bus.logsub_en, bus.exp2_en, bus.out_valid, bus.busy, bus.done};
    endfunction

    // Schedule model: bit order max,sub,exp,add,log,presub,logsub,exp2,out_valid,busy,done
    function automatic logic [10:0] exp_ctl(int n, int k);
        logic [10:0] v;
        v = '0;
        if (n == 0) begin
            v[1] = (k == 1);
            v[0] = (k == 1);
            return v;
        end
        v[10] = (k >= 2)       && (k <= n + 1);
        v[9]  = (k >= n + 3)   && (k <= 2*n + 2);
        v[8]  = (k >= n + 4)   && (k <= 2*n + 3);
        v[7]  = (k >= n + 5)   && (k <= 2*n + 4);
        v[6]  = (k == 2*n + 5);
        v[5]  = (k >= 2*n + 7) && (k <= 3*n + 6);
        v[4]  = (k >= 2*n + 8) && (k <= 3*n + 7);
        v[3]  = (k >= 2*n + 9) && (k <= 3*n + 8);
        v[2]  = (k >= 2*n + 10) && (k <= 3*n + 9);
        v[1]  = (k >= 1)       && (k <= 3*n + 10);
        v[0]  = (k == 3*n + 10);
        return v;
    endfunction

    function automatic logic [15:0] exp_cnt(int n, int k);
`ifdef SOFTMAX_CYCLE_CNT_EN
        int len;
        len = (n == 0) ? 1 : 3*n + 10;
        return 16'(((k - 1) < len) ? (k - 1) : len);
`else
        return 16'(n * 0 + k * 0);
`endif
    endfunction

    // Cycle k is the period after the k-th edge following the accepting edge;
    // sampled on the falling edge. p1/p2 raise start, rst_at raises reset, during that cycle.
    task automatic run_capture(input int s, input int e, input int ncyc,
                               input int p1, input int p2, input int rst_at);
        int g;
        g = 0;
        while (bus.busy !== 1'b0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_wait busy=%b after %0d cycles, required 0", bus.busy, g);
        end
        @(negedge clk);
        bus.start_addr = 8'(s);
        bus.end_addr   = 8'(e);
        bus.start      = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            cap_ctl[k] = ctl_now();
            cap_a[k]   = bus.addr;
            cap_s0[k]  = bus.sub0_addr;
            cap_s1[k]  = bus.sub1_addr;
            cap_cnt[k] = bus.cycle_cnt;
            if (k == 1) begin
                bus.start_addr = 8'(s + 77);
                bus.end_addr   = 8'(e + 13);
            end
            bus.start = (k == p1) || (k == p2);
            reset     = (k == rst_at);
        end
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.start_addr = 8'd0;
        bus.end_addr = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (ctl_now() !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_ctl got %b want %b", ctl_now(), 11'd0);
        end
        vectors++;
        if ({bus.addr, bus.sub0_addr, bus.sub1_addr} !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_addr got %h want 000000", {bus.addr, bus.sub0_addr, bus.sub1_addr});
        end
        vectors++;
        if (bus.cycle_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got %0d want 0", bus.cycle_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_run(input string name, input int s, input int e);
        int n, ncyc;
        logic [7:0] wa;
        n = e - s;
        ncyc = 3*n + 14;
        run_capture(s, e, ncyc, 0, 0, 0);
        for (int k = 1; k <= ncyc; k++) begin
            vectors++;
            if (cap_ctl[k] !== exp_ctl(n, k)) begin
                miscompares++;
                $display("FAIL %s ctl cyc%0d got %b want %b", name, k, cap_ctl[k], exp_ctl(n, k));
            end
            wa = 8'(s + ((k < n) ? k : n) - 1);
            vectors++;
            if (cap_a[k] !== wa) begin
                miscompares++;
                $display("FAIL %s addr cyc%0d got %0d want %0d", name, k, cap_a[k], wa);
            end
            if (k >= n + 2) begin
                wa = 8'(s + (((k - n - 2) < n - 1) ? (k - n - 2) : n - 1));
                vectors++;
                if (cap_s0[k] !== wa) begin
                    miscompares++;
                    $display("FAIL %s sub0_addr cyc%0d got %0d want %0d", name, k, cap_s0[k], wa);
                end
            end
            if (k >= 2*n + 6) begin
                wa = 8'(s + (((k - 2*n - 6) < n - 1) ? (k - 2*n - 6) : n - 1));
                vectors++;
                if (cap_s1[k] !== wa) begin
                    miscompares++;
                    $display("FAIL %s sub1_addr cyc%0d got %0d want %0d", name, k, cap_s1[k], wa);
                end
            end
            vectors++;
            if (cap_cnt[k] !== exp_cnt(n, k)) begin
                miscompares++;
                $display("FAIL %s cycle_cnt cyc%0d got %0d want %0d", name, k, cap_cnt[k], exp_cnt(n, k));
            end
        end
    endtask

    // Runs right after a start=4,end=8 run, so all addresses sit at 7.
    task automatic test_empty();
        run_capture(5, 5, 6, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            vectors++;
            if (cap_ctl[k] !== exp_ctl(0, k)) begin
                miscompares++;
                $display("FAIL empty ctl cyc%0d got %b want %b", k, cap_ctl[k], exp_ctl(0, k));
            end
            vectors++;
            if ({cap_a[k], cap_s0[k], cap_s1[k]} !== {8'd7, 8'd7, 8'd7}) begin
                miscompares++;
                $display("FAIL empty addr cyc%0d got %h want 070707", k, {cap_a[k], cap_s0[k], cap_s1[k]});
            end
            vectors++;
            if (cap_cnt[k] !== exp_cnt(0, k)) begin
                miscompares++;
                $display("FAIL empty cycle_cnt cyc%0d got %0d want %0d", k, cap_cnt[k], exp_cnt(0, k));
            end
        end
    endtask

    task automatic test_start_ignored();
        int ndone;
        ndone = 0;
        run_capture(4, 8, 30, 10, 22, 0);
        for (int k = 1; k <= 30; k++) begin
            ndone += int'(cap_ctl[k][0]);
            vectors++;
            if (cap_ctl[k] !== exp_ctl(4, k)) begin
                miscompares++;
                $display("FAIL start_ignored ctl cyc%0d got %b want %b", k, cap_ctl[k], exp_ctl(4, k));
            end
        end
        vectors++;
        if (ndone != 1) begin
            miscompares++;
            $display("FAIL start_ignored done_count got %0d want 1", ndone);
        end
    endtask

    task automatic test_reset_mid();
        run_capture(4, 8, 14, 0, 0, 9);
        for (int k = 1; k <= 14; k++) begin
            vectors++;
            if (cap_ctl[k] !== ((k <= 9) ? exp_ctl(4, k) : 11'd0)) begin
                miscompares++;
                $display("FAIL reset_mid ctl cyc%0d got %b want %b", k, cap_ctl[k],
                         (k <= 9) ? exp_ctl(4, k) : 11'd0);
            end
            if (k >= 10) begin
                vectors++;
                if ({cap_a[k], cap_s0[k], cap_s1[k], cap_cnt[k]} !== 40'd0) begin
                    miscompares++;
                    $display("FAIL reset_mid addr_cnt cyc%0d got %h want 0", k,
                             {cap_a[k], cap_s0[k], cap_s1[k], cap_cnt[k]});
                end
            end
        end
        run_capture(1, 5, 26, 0, 0, 0);
        for (int k = 1; k <= 26; k++) begin
            vectors++;
            if (cap_ctl[k] !== exp_ctl(4, k)) begin
                miscompares++;
                $display("FAIL reset_mid rerun ctl cyc%0d got %b want %b", k, cap_ctl[k], exp_ctl(4, k));
            end
        end
    endtask

    task automatic test_cycle_cnt_hold();
        logic [15:0] want;
        run_capture(4, 8, 23, 0, 0, 0);
        repeat (15) @(negedge clk);
`ifdef SOFTMAX_CYCLE_CNT_EN
        want = 16'd22;
`else
        want = 16'd0;
`endif
        vectors++;
        if (bus.cycle_cnt !== want) begin
            miscompares++;
            $display("FAIL cycle_cnt_hold got %0d want %0d", bus.cycle_cnt, want);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cycle_cnt_hold busy got %b want 0", bus.busy);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.start_addr = 8'd0;
        bus.end_addr = 8'd0;
        test_reset();
        test_run("n1", 0, 1);
        test_run("n4", 4, 8);
        test_empty();
        test_run("n3_high", 250, 253);
        test_run("n255", 0, 255);
        test_start_ignored();
        test_reset_mid();
        test_cycle_cnt_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
